// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported, variable-latency memory between the fetch
// stage and the memory-access stage, with ack timeout and fetch flush handling.
module mem_port_arbiter #(
    parameter int ACK_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    input  logic        flush,
    output logic        m_req,
    output logic        m_we,
    output logic [3:0]  m_be,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ack,
    output logic        stall_req,
    output logic        bus_err
);

    typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       addr_q, wdata_q;
    logic [3:0]        be_q;
    logic              we_q;
    logic              drop_q;
    logic              i_ready_q, d_ready_q;
    logic              busy, timeout;

    assign busy    = (state == I_BUSY) || (state == D_BUSY);
    assign timeout = busy && !m_ack && (cnt == CNT_LAST);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (d_req)
                    state_nx = D_BUSY;
                else if (i_req && !flush)
                    state_nx = I_BUSY;
            end
            I_BUSY, D_BUSY: begin
                if (m_ack || timeout)
                    state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; the async reset clears every register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            we_q      <= 1'b0;
            drop_q    <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            state     <= state_nx;
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
            bus_err   <= 1'b0;
            case (state)
                IDLE: begin
                    cnt    <= '0;
                    drop_q <= 1'b0;
                    // Data wins: it belongs to the older instruction in the pipe.
                    if (d_req) begin
                        addr_q  <= d_addr;
                        we_q    <= d_we;
                        be_q    <= d_be;
                        wdata_q <= d_wdata;
                    end else if (i_req && !flush) begin
                        addr_q  <= i_addr;
                        we_q    <= 1'b0;
                        be_q    <= 4'hF;
                        wdata_q <= '0;
                    end
                end
                I_BUSY: begin
                    if (flush)
                        drop_q <= 1'b1;
                    if (m_ack || timeout) begin
                        i_rdata   <= timeout ? 32'd0 : m_rdata;
                        i_ready_q <= !(drop_q || flush);
                        bus_err   <= timeout;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                D_BUSY: begin
                    if (m_ack || timeout) begin
                        if (!we_q)
                            d_rdata <= timeout ? 32'd0 : m_rdata;
                        d_ready_q <= 1'b1;
                        bus_err   <= timeout;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    cnt    <= '0;
                    drop_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign m_req   = busy;
    assign m_we    = busy && we_q;
    assign m_be    = be_q;
    assign m_addr  = addr_q;
    assign m_wdata = wdata_q;

    // A flush landing in the DONE cycle still cancels delivery of that fetch.
    assign i_ready = i_ready_q && !flush;
    assign d_ready = d_ready_q;

    // A dropped fetch keeps the fetch stage stalled until its memory access ends.
    assign stall_req = !rst && ((d_req && !d_ready) ||
                                (i_req && !i_ready && !flush) ||
                                (i_req && (state == I_BUSY) && (drop_q || flush)));

endmodule
